ram_port_arbiter: RTL
=====================

Name: ram_port_arbiter

Overview:
- Shares one single-port synchronous RAM (address, write enable, write data, read data q) between two requesters.
- Typical requester pairing: requester 0 is the memory test sequencer, requester 1 is functional/host logic.
- Arbitration is round-robin with an optional lock, so a requester can hold the port across multi-access sequences such as a read/write/read element.
- Read data returns to the requester that issued the read, with a fixed latency and a one-cycle valid strobe.

Parameters:
- AW, 8, address width.
- DW, 8, data width.
- RD_LAT, 1, RAM read latency in clocks from the RAM address edge to q valid. Legal values are 1 or 2.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- r0_req  input  1  requester 0 access request.
- r0_we  input  1  requester 0 access type: 1 = write, 0 = read.
- r0_lock  input  1  requester 0 holds the port after the current access.
- r0_addr  input  AW  requester 0 address.
- r0_wdata  input  DW  requester 0 write data.
- r0_gnt  output  1  combinational grant; the access is accepted at the edge where req&gnt=1.
- r0_rvalid  output  1  one-cycle read-data strobe for requester 0.
- r0_rdata  output  DW  read data for requester 0; equals ram_q.
- r1_*  identical set for requester 1.
- ram_addr  output  AW  registered RAM address.
- ram_wren  output  1  registered RAM write enable; a one-cycle pulse per write.
- ram_data  output  DW  registered RAM write data.
- ram_q  input  DW  RAM read data.

Behaviour:
- Reset (synchronous): ram_addr=0, ram_wren=0, ram_data=0; all rvalid=0; lock released; last_served=1, so requester 0 wins the first tie; read-tag pipeline cleared.
  - Reads in flight when reset is asserted are discarded and never produce rvalid.
- Grant (combinational):
  - At most one gnt is high in any cycle, and a gnt is never high without its own req.
  - Lock owner present: only the owner can be granted; the other gnt=0.
  - No lock owner, single req: that requester is granted.
  - No lock owner, both req: grant the requester that is not last_served.
- Acceptance at edge T (req&gnt):
  - ram_addr, ram_wren(=we) and ram_data are registered from the winner, visible in cycle T+1.
  - last_served is updated to the winner.
  - If the access is a read, the winner's tag enters the read pipeline.
- Idle edge (no acceptance): ram_wren=0; ram_addr and ram_data hold their previous values.
- Read return:
  - rN_rvalid is high for exactly one cycle, RD_LAT+1 edges after acceptance: 2 cycles for RD_LAT=1, 3 for RD_LAT=2.
  - Read data comes back in issue order, to the issuing requester only.
  - rN_rdata = ram_q at all times; it is meaningful only when rvalid=1.
- Throughput: one access per cycle, with back-to-back accesses from either requester. Reads and writes can be freely interleaved.
- Lock:
  - An accepted access with lock=1 makes that requester the lock owner.
  - The owner keeps exclusivity while its lock=1 is sampled each edge, even in cycles where its req=0.
  - Lock is released at the first edge sampling lock=0 from the owner.
  - While locked, the other requester's request stays pending; it is not dropped, and it wins the first tie-free cycle after release.
- Hazards:
  - A write followed next cycle by a read of the same address returns the newly written data; ordering is preserved by the single port.
  - A write from one requester and a read from the other can never be issued in the same cycle.
- Address and data pass through unmodified; no wrap-around or arithmetic is performed.
- Mid-operation reset behaves exactly as the reset defined above.

Test Plan:
- After reset, r0 writes 0x55 to 0x03 with r1 idle → r0_gnt=1 in the same cycle; next cycle ram_wren=1, ram_addr=0x03, ram_data=0x55; the cycle after, ram_wren=0.
- r0 reads 0x03 (RD_LAT=1, RAM model holds 0x55) → r0_rvalid=1 for one cycle, 2 cycles after acceptance, with r0_rdata=0x55; r1_rvalid stays 0.
- r0_req and r1_req held high, lock=0, starting from reset → grants alternate 0,1,0,1,…; reads issued that way return alternating tagged rvalids in issue order.
- r1 accesses with lock=1 for 4 cycles while r0_req is held → r0_gnt=0 for all 4 cycles and r1 wins 4 consecutive accesses; after r1_lock=0 is sampled, r0_gnt=1 on the next cycle.
- Reset asserted the cycle after a read is accepted → no rvalid follows; on the next cycle ram_wren=0, ram_addr=0 and all gnt follow the reset arbitration state.
- RD_LAT=2 build, back-to-back reads r0@0x10 (0xAA), r1@0x11 (0x55) → r0_rvalid with 0xAA 3 cycles after its acceptance, then r1_rvalid with 0x55 one cycle later.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// Two-requester round-robin arbiter with lock in front of one single-port synchronous RAM.
// Read data is steered back to the issuing requester via a tag pipeline matched to RD_LAT.
module ram_port_arbiter #(
    parameter int unsigned AW     = 8,
    parameter int unsigned DW     = 8,
    parameter int unsigned RD_LAT = 1  // 1 or 2
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          r0_req,
    input  logic          r0_we,
    input  logic          r0_lock,
    input  logic [AW-1:0] r0_addr,
    input  logic [DW-1:0] r0_wdata,
    output logic          r0_gnt,
    output logic          r0_rvalid,
    output logic [DW-1:0] r0_rdata,

    input  logic          r1_req,
    input  logic          r1_we,
    input  logic          r1_lock,
    input  logic [AW-1:0] r1_addr,
    input  logic [DW-1:0] r1_wdata,
    output logic          r1_gnt,
    output logic          r1_rvalid,
    output logic [DW-1:0] r1_rdata,

    output logic [AW-1:0] ram_addr,
    output logic          ram_wren,
    output logic [DW-1:0] ram_data,
    input  logic [DW-1:0] ram_q
);

    // One stage for the registered address plus RD_LAT stages inside the RAM.
    localparam int unsigned Depth = RD_LAT + 1;

    logic          lock_act_q, lock_act_d;
    logic          lock_own_q, lock_own_d;
    logic          last_q, last_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          wren_q, wren_d;
    logic [DW-1:0] data_q, data_d;
    logic [Depth-1:0] vld_q, vld_d;
    logic [Depth-1:0] tag_q, tag_d;

    logic          gnt0, gnt1;
    logic          acc;
    logic          win;
    logic          win_we;
    logic          win_lock;
    logic          own_lock;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_data;

    // Grant: lock owner is exclusive; otherwise a tie goes to the requester not served last.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (lock_act_q) begin
            gnt0 = r0_req & ~lock_own_q;
            gnt1 = r1_req & lock_own_q;
        end else if (r0_req && r1_req) begin
            gnt0 = last_q;
            gnt1 = ~last_q;
        end else begin
            gnt0 = r0_req;
            gnt1 = r1_req;
        end
    end

    assign r0_gnt = gnt0;
    assign r1_gnt = gnt1;

    always_comb begin
        acc      = gnt0 | gnt1;
        win      = gnt1;
        win_we   = gnt1 ? r1_we    : r0_we;
        win_lock = gnt1 ? r1_lock  : r0_lock;
        win_addr = gnt1 ? r1_addr  : r0_addr;
        win_data = gnt1 ? r1_wdata : r0_wdata;
        own_lock = lock_own_q ? r1_lock : r0_lock;
    end

    always_comb begin
        addr_d     = addr_q;
        data_d     = data_q;
        wren_d     = 1'b0;
        last_d     = last_q;
        lock_act_d = lock_act_q;
        lock_own_d = lock_own_q;

        if (acc) begin
            addr_d = win_addr;
            data_d = win_data;
            wren_d = win_we;
            last_d = win;
        end

        // The owner's lock is watched every edge, whether or not it is requesting.
        if (lock_act_q) begin
            lock_act_d = own_lock;
        end else if (acc && win_lock) begin
            lock_act_d = 1'b1;
            lock_own_d = win;
        end

        vld_d = {vld_q[Depth-2:0], acc & ~win_we};
        tag_d = {tag_q[Depth-2:0], win};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lock_act_q <= 1'b0;
            lock_own_q <= 1'b0;
            last_q     <= 1'b1;
            addr_q     <= '0;
            wren_q     <= 1'b0;
            data_q     <= '0;
            vld_q      <= '0;
            tag_q      <= '0;
        end else begin
            lock_act_q <= lock_act_d;
            lock_own_q <= lock_own_d;
            last_q     <= last_d;
            addr_q     <= addr_d;
            wren_q     <= wren_d;
            data_q     <= data_d;
            vld_q      <= vld_d;
            tag_q      <= tag_d;
        end
    end

    assign ram_addr  = addr_q;
    assign ram_wren  = wren_q;
    assign ram_data  = data_q;

    assign r0_rvalid = vld_q[Depth-1] & ~tag_q[Depth-1];
    assign r1_rvalid = vld_q[Depth-1] & tag_q[Depth-1];
    assign r0_rdata  = ram_q;
    assign r1_rdata  = ram_q;

endmodule
